// File: rtl/gray_ptr_sync_if.sv
// gray_ptr_sync_if
//   Bundles the pointer-side signals of one gray_ptr_sync instance.
//   master : the driver side, which supplies the Gray pointer and the error clear
//            and observes the synchronised results.
//   slave  : the synchroniser itself.
// Signals
//   InData  Gray-coded pointer from the source domain (asynchronous to clk)
//   ErrClr  synchronous clear of GrayErr
//   OutData synchronised Gray pointer
//   OutBin  registered binary decode of OutData
//   Changed one-cycle pulse on each new synchronised value
//   GrayErr sticky multi-bit-change flag
interface gray_ptr_sync_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] InData;
    logic             ErrClr;
    logic [WIDTH-1:0] OutData;
    logic [WIDTH-1:0] OutBin;
    logic             Changed;
    logic             GrayErr;

    modport master (
        output InData,
        output ErrClr,
        input  OutData,
        input  OutBin,
        input  Changed,
        input  GrayErr
    );

    modport slave (
        input  InData,
        input  ErrClr,
        output OutData,
        output OutBin,
        output Changed,
        output GrayErr
    );
endinterface

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync
//   Multi-rank synchroniser for a Gray-coded FIFO pointer entering the clk
//   domain. The pointer passes through STAGES flop ranks with no logic between
//   them; the last rank is decoded to binary (registered), compared with the
//   previous synchronised sample to produce a one-cycle Changed strobe, and,
//   optionally, checked for multi-bit steps (sticky GrayErr).
// Parameters
//   WIDTH  pointer width, 2..16
//   STAGES synchroniser ranks, 2..4
// Ports
//   clk  destination-domain clock
//   RST  asynchronous active-low reset; clears every register immediately
//   bus  gray_ptr_sync_if.slave: InData, ErrClr in; OutData, OutBin, Changed,
//        GrayErr out
// Build option
//   SYNC_GRAY_CHECK_EN : when defined, the popcount checker, GrayErr register
//   and ErrClr handling are built. When undefined, GrayErr is constant 0 and
//   ErrClr is ignored.
module gray_ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              RST,
    gray_ptr_sync_if.slave    bus
);

    // Reject illegal configurations at elaboration time.
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("gray_ptr_sync: WIDTH must be within 2..16");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be within 2..4");
    end
    if ($bits(bus.InData) != WIDTH) begin : g_bad_if_width
        $error("gray_ptr_sync: interface WIDTH does not match module WIDTH");
    end

    logic [WIDTH-1:0] rank_reg [STAGES];
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] out_bin_reg;
    logic             changed_reg;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] bin_next;

    assign out_data = rank_reg[STAGES-1];

    // Gray-to-binary: MSB passes through, each lower bit folds in the binary
    // bit above it. Computed ahead of the register so OutBin is a flop output.
    always_comb begin
        bin_next = '0;
        bin_next[WIDTH-1] = out_data[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin_next[i] = bin_next[i+1] ^ out_data[i];
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < STAGES; i++) begin
                rank_reg[i] <= '0;
            end
            prev_reg    <= '0;
            out_bin_reg <= '0;
            changed_reg <= 1'b0;
        end else begin
            // Plain flop chain: nothing may sit between ranks.
            rank_reg[0] <= bus.InData;
            for (int i = 1; i < STAGES; i++) begin
                rank_reg[i] <= rank_reg[i-1];
            end
            prev_reg    <= out_data;
            out_bin_reg <= bin_next;
            changed_reg <= (out_data != prev_reg);
        end
    end

    assign bus.OutData = out_data;
    assign bus.OutBin  = out_bin_reg;
    assign bus.Changed = changed_reg;

`ifdef SYNC_GRAY_CHECK_EN
    logic [WIDTH-1:0] diff;
    logic             multi_bit;
    logic             gray_err_reg;

    // More than one bit set <=> diff is non-zero and not a power of two.
    assign diff      = out_data ^ prev_reg;
    assign multi_bit = (diff & (diff - WIDTH'(1))) != '0;

    // A fresh violation takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            gray_err_reg <= 1'b0;
        end else if (multi_bit) begin
            gray_err_reg <= 1'b1;
        end else if (bus.ErrClr) begin
            gray_err_reg <= 1'b0;
        end
    end

    assign bus.GrayErr = gray_err_reg;
`else
    logic unused_err_clr;

    assign unused_err_clr = bus.ErrClr;
    assign bus.GrayErr    = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync
//   Drives a STAGES=2 and a STAGES=3 instance (WIDTH=4) with the same stimulus
//   and compares every output, every cycle, against a reference model built
//   from the history of sampled inputs.
module tb_gray_ptr_sync;

    localparam int W = 4;

    logic clk;
    logic RST;

    int tests_run    = 0;
    int tests_failed = 0;

    gray_ptr_sync_if #(.WIDTH(W)) if2 ();
    gray_ptr_sync_if #(.WIDTH(W)) if3 ();

    gray_ptr_sync #(.WIDTH(W), .STAGES(2)) u_dut2 (
        .clk (clk),
        .RST (RST),
        .bus (if2.slave)
    );

    gray_ptr_sync #(.WIDTH(W), .STAGES(3)) u_dut3 (
        .clk (clk),
        .RST (RST),
        .bus (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: every InData value sampled since the last reset.
    logic [W-1:0] samp[$];
    int           n_edges;
    logic         err2;
    logic         err3;

    function automatic logic [W-1:0] exp_od(int n, int s);
        int m;
        m = n - s + 1;
        if (m < 1) return '0;
        return samp[m-1];
    endfunction

    function automatic logic [W-1:0] to_bin(logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic bit multi_change(logic [W-1:0] a, logic [W-1:0] b);
        int cnt;
        cnt = 0;
        for (int i = 0; i < W; i++) if (a[i] != b[i]) cnt++;
        return cnt > 1;
    endfunction

    function automatic logic [W-1:0] gray(int i);
        logic [W-1:0] v;
        v = W'(i);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s at edge %0d: got %h, expected %h", tag, n_edges, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic e2;
        logic e3;
`ifdef SYNC_GRAY_CHECK_EN
        e2 = err2;
        e3 = err3;
`else
        e2 = 1'b0;
        e3 = 1'b0;
`endif
        check("s2.OutData", 16'(if2.OutData), 16'(exp_od(n_edges, 2)));
        check("s2.OutBin",  16'(if2.OutBin),  16'(to_bin(exp_od(n_edges - 1, 2))));
        check("s2.Changed", 16'(if2.Changed), 16'(exp_od(n_edges - 1, 2) != exp_od(n_edges - 2, 2)));
        check("s2.GrayErr", 16'(if2.GrayErr), 16'(e2));
        check("s3.OutData", 16'(if3.OutData), 16'(exp_od(n_edges, 3)));
        check("s3.OutBin",  16'(if3.OutBin),  16'(to_bin(exp_od(n_edges - 1, 3))));
        check("s3.Changed", 16'(if3.Changed), 16'(exp_od(n_edges - 1, 3) != exp_od(n_edges - 2, 3)));
        check("s3.GrayErr", 16'(if3.GrayErr), 16'(e3));
        $display("[TB] edge=%0d rst=%b in=%b clr=%b | s2 od=%b bin=%b chg=%b err=%b | s3 od=%b bin=%b chg=%b err=%b",
                 n_edges, RST, if2.InData, if2.ErrClr,
                 if2.OutData, if2.OutBin, if2.Changed, if2.GrayErr,
                 if3.OutData, if3.OutBin, if3.Changed, if3.GrayErr);
    endtask

    // One clock of stimulus: drive, clock, update model, check on the falling edge.
    task automatic step(input logic [W-1:0] din, input logic clr);
        if2.InData = din;
        if3.InData = din;
        if2.ErrClr = clr;
        if3.ErrClr = clr;
        @(posedge clk);
        n_edges++;
        samp.push_back(din);
        if (multi_change(exp_od(n_edges - 1, 2), exp_od(n_edges - 2, 2))) err2 = 1'b1;
        else if (clr) err2 = 1'b0;
        if (multi_change(exp_od(n_edges - 1, 3), exp_od(n_edges - 2, 3))) err3 = 1'b1;
        else if (clr) err3 = 1'b0;
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset applied away from the rising edge; outputs must clear at once.
    task automatic do_reset(input int hold);
        RST = 1'b0;
        #1;
        samp.delete();
        n_edges = 0;
        err2 = 1'b0;
        err3 = 1'b0;
        compare_all();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
        RST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        logic [W-1:0] din;
        logic clr;

        n_edges = 0;
        err2 = 1'b0;
        err3 = 1'b0;
        RST = 1'b1;
        if2.InData = 4'b1010;
        if3.InData = 4'b1010;
        if2.ErrClr = 1'b0;
        if3.ErrClr = 1'b0;
        #2;

        // Reset held with non-zero input, then release with it still present.
        do_reset(3);
        for (int i = 0; i < 6; i++) step(4'b1010, 1'b0);

        // Latency: 0000 steady, then a single step to 0001.
        do_reset(1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) step(4'b0001, 1'b0);

        // Full Gray count with wrap back to zero, one step per cycle.
        do_reset(1);
        for (int i = 0; i <= 16; i++) step(gray(i % 16), 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);

        // Violation, clear alone, then clear coinciding with a new violation.
        for (int i = 0; i < 5; i++) step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0011, 1'b0);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

        // Mid-transfer reset during 0001 -> 0011.
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0);
        step(4'b0011, 1'b0);
        do_reset(0);
        for (int i = 0; i < 7; i++) step(4'b0011, 1'b0);

        // Randomised: mostly legal Gray steps, occasional jumps, clears and resets.
        do_reset(1);
        cur = 0;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset($urandom_range(0, 2));
                cur = 0;
            end
            case ($urandom_range(0, 7))
                0:       din = W'($urandom);
                1, 2:    begin din = gray(cur); end
                3:       begin cur = (cur + 15) % 16; din = gray(cur); end
                default: begin cur = (cur + 1) % 16; din = gray(cur); end
            endcase
            clr = ($urandom_range(0, 5) == 0);
            step(din, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
